pri_iq_framer: RTL
==================

PRI_IQ_FRAMER -- requirements
Module: pri_iq_framer

Interface
REQ-001 Parameter N_CH, default 4: number of DDC I/Q channels presented in parallel.
REQ-002 Parameter IQ_W, default 18: width of each I and Q sample; 2*IQ_W SHALL be >= 32.
REQ-003 Parameter FIFO_AW, default 9: output FIFO address width (depth 2**FIFO_AW words).
REQ-004 clk_100M  in  1: sole clock; every port is synchronous to it.
REQ-005 rst_n  in  1: reset, synchronous, active-low.
REQ-006 PRI  in  1: pulse repetition interval marker, level signal; its rising edge starts a frame.
REQ-007 in_valid  in  1: in_data holds one sample set this cycle.
REQ-008 in_data  in  N_CH*2*IQ_W: channel k occupies {Q,I} at bits [(k+1)*2*IQ_W-1 : k*2*IQ_W].
REQ-009 ch_sel  in  max(1,clog2(N_CH)): channel to capture; sampled at frame start.
REQ-010 win_start  in  16: valid samples skipped after PRI edge; sampled at frame start.
REQ-011 win_len  in  16: samples captured per frame; sampled at frame start.
REQ-012 channel_up  in  1: Aurora channel status.
REQ-013 hard_err, soft_err, frame_err  in  1 each: Aurora error pulses, one count per high cycle.
REQ-014 err_clr  in  1: clears the error and skip counters.
REQ-015 out_valid  out  1 / out_ready  in  1 / out_data  out  2*IQ_W / out_last  out  1: output stream; a word transfers when out_valid and out_ready are both high.
REQ-016 err_count  out  32: {hard_cnt[7:0], soft_cnt[7:0], frame_cnt[7:0], skip_cnt[7:0]}.
REQ-017 pri_cnt  out  16: number of frames started, wraps from 0xFFFF to 0.
REQ-018 busy  out  1: high when the FSM is not IDLE.

Function
REQ-019 PRI edge detection SHALL use a one-cycle registered copy of PRI; the edge is PRI & ~PRI_d.
REQ-020 FSM states SHALL be IDLE, DELAY, CAPTURE and TRAILER.
REQ-021 IDLE + edge + channel_up + FIFO free >= 3: write the header word, latch ch_sel/win_start/win_len, increment pri_cnt, go to DELAY (or to CAPTURE if win_start = 0).
REQ-022 IDLE + edge with channel_up low or FIFO free < 3: no frame is written, skip_cnt increments, FSM stays in IDLE.
REQ-023 Header word: low 32 bits = {8'hA5, pri_cnt(pre-increment), 8'(ch_sel)}; upper bits zero.
REQ-024 DELAY: count in_valid cycles; after win_start of them, go to CAPTURE.
REQ-025 CAPTURE: on each in_valid, write the {Q,I} of the latched channel; after win_len writes, go to TRAILER; win_len = 0 goes straight to TRAILER.
REQ-026 In CAPTURE, when FIFO free <= 1 (one slot reserved for the trailer), drop the sample, do not count it, and set flag bit0 (overflow).
REQ-027 A PRI edge while in DELAY or CAPTURE SHALL set flag bit1 (truncated), go to TRAILER, and latch a pending start that is served in IDLE on the next cycle under REQ-021/022.
REQ-028 channel_up low while in DELAY or CAPTURE SHALL set flag bit2 (link down) and go to TRAILER.
REQ-029 TRAILER: write {8'h5A, flags[7:0], captured_count[15:0]} with out_last=1 for that word, clear flags, go to IDLE; lasts exactly one cycle.
REQ-030 The FIFO SHALL be first-word-fall-through: out_valid rises 1 cycle after a write into an empty FIFO; out_last travels with its word.
REQ-031 Error counters SHALL be 8-bit and saturate at 0xFF; err_clr has priority over a simultaneous increment.

Reset
REQ-032 Under rst_n=0: FSM in IDLE, FIFO empty, out_valid=0, out_last=0, out_data=0, err_count=0, pri_cnt=0, busy=0, flags=0, pending start cleared, PRI_d=0.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame; no trailer is emitted.

Structure
REQ-034 Package pri_iq_pkg SHALL hold the state enum, the header and trailer tags (8'hA5, 8'h5A), and the flag bit indices.
REQ-035 Sub-module pri_iq_fifo SHALL be a parametrised synchronous FWFT FIFO (data + last bit) and SHALL report its free count.

Verification
REQ-036 N_CH=4, ch_sel=2, win_start=3, win_len=5, continuous in_valid, out_ready=1 -> header, channel-2 samples 4..8, trailer 0x5A_00_0005 with out_last.
REQ-037 out_ready=0 with FIFO_AW=3 and win_len=20 -> overflow flag bit0 set, trailer count = 5, no trailer lost.
REQ-038 Second PRI edge at the 2nd captured sample -> trailer flags=0x02 with count=2, then a new header whose pri_cnt field is 1.
REQ-039 channel_up=0 at the PRI edge -> no output words, skip_cnt=1; channel_up dropped mid-capture -> trailer flags=0x04.
REQ-040 300 hard_err pulses then err_clr coinciding with a soft_err pulse -> hard_cnt reads 0xFF, then all counters read 0.
REQ-041 rst_n=0 for one cycle mid-CAPTURE -> next cycle all outputs at reset values and FIFO empty.

Source files
------------

// File: rtl/pri_iq_pkg.sv
// Shared types and constants for the PRI-gated I/Q framer: FSM states, frame tags, flag bits.
package pri_iq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_CAPTURE,
        ST_TRAILER
    } state_t;

    localparam logic [7:0] HDR_TAG = 8'hA5;
    localparam logic [7:0] TRL_TAG = 8'h5A;

    localparam int FLAG_OVF   = 0;
    localparam int FLAG_TRUNC = 1;
    localparam int FLAG_LINK  = 2;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
        return (inc && (v != 8'hFF)) ? v + 8'd1 : v;
    endfunction

endpackage

// File: rtl/pri_iq_fifo.sv
// Synchronous first-word-fall-through FIFO carrying data plus a last bit; 1-cycle write-to-valid latency.
// Writes into a full FIFO are ignored and reads wait on rd_ready; holds 2**AW-1 words and reports the free count.
module pri_iq_fifo #(
    parameter int W  = 36,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          wr_last,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [W-1:0]  rd_data,
    output logic          rd_last,
    output logic [AW:0]   free
);
    localparam int DEPTH = 2 ** AW;
    // One ring slot stays empty so the pointers alone can tell full from empty.
    localparam logic [AW:0]   CAP     = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [W:0]    mem [DEPTH];
    logic [W:0]    head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   used;
    logic          do_wr;
    logic          do_rd;

    assign do_wr    = wr_en && (used != CAP);
    assign do_rd    = rd_valid && rd_ready;
    assign rd_valid = (used != '0);
    assign head     = mem[rd_ptr];
    assign rd_data  = rd_valid ? head[W-1:0] : '0;
    assign rd_last  = rd_valid & head[W];
    assign free     = CAP - used;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= {wr_last, wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_wr && !do_rd) begin
                used <= used + CNT_ONE;
            end else if (!do_wr && do_rd) begin
                used <= used - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/pri_iq_framer.sv
// Frames one DDC channel per PRI into header/samples/trailer words; header written on the PRI-edge clock, FWFT output 1 cycle later.
// out_ready stalls the FIFO; when nearly full, samples are dropped (overflow flag) while one slot is kept for the trailer.
module pri_iq_framer
    import pri_iq_pkg::*;
#(
    parameter  int N_CH    = 4,
    parameter  int IQ_W    = 18,
    parameter  int FIFO_AW = 9,
    localparam int SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int OW      = 2 * IQ_W
) (
    input  logic                 clk_100M,
    input  logic                 rst_n,
    input  logic                 PRI,
    input  logic                 in_valid,
    input  logic [N_CH*OW-1:0]   in_data,
    input  logic [SEL_W-1:0]     ch_sel,
    input  logic [15:0]          win_start,
    input  logic [15:0]          win_len,
    input  logic                 channel_up,
    input  logic                 hard_err,
    input  logic                 soft_err,
    input  logic                 frame_err,
    input  logic                 err_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OW-1:0]        out_data,
    output logic                 out_last,
    output logic [31:0]          err_count,
    output logic [15:0]          pri_cnt,
    output logic                 busy
);
    localparam logic [FIFO_AW:0] FREE_HDR = (FIFO_AW+1)'(3);
    localparam logic [FIFO_AW:0] FREE_RSV = (FIFO_AW+1)'(1);

    state_t           state;
    state_t           state_nxt;
    logic             pri_d;
    logic             pri_edge;
    logic             pending;
    logic [SEL_W-1:0] ch_q;
    logic [15:0]      ws_q;
    logic [15:0]      wl_q;
    logic [15:0]      dly_cnt;
    logic [15:0]      cap_cnt;
    logic [7:0]       flags;
    logic [7:0]       set_flags;
    logic [15:0]      pri_cnt_q;
    logic [7:0]       hard_cnt;
    logic [7:0]       soft_cnt;
    logic [7:0]       frame_cnt;
    logic [7:0]       skip_cnt;

    logic             start_frame;
    logic             skip_frame;
    logic             dly_inc;
    logic             cap_wr;
    logic             wr_en;
    logic [OW-1:0]    wr_data;
    logic             wr_last;
    logic [FIFO_AW:0] fifo_free;
    logic [OW-1:0]    sample;

    assign pri_edge  = PRI & ~pri_d;
    assign busy      = (state != ST_IDLE);
    assign pri_cnt   = pri_cnt_q;
    assign err_count = {hard_cnt, soft_cnt, frame_cnt, skip_cnt};

    always_comb begin
        sample = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_q == SEL_W'(k)) begin
                sample = in_data[k*OW +: OW];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        skip_frame  = 1'b0;
        dly_inc     = 1'b0;
        cap_wr      = 1'b0;
        set_flags   = '0;
        wr_en       = 1'b0;
        wr_data     = '0;
        wr_last     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pri_edge || pending) begin
                    if (channel_up && (fifo_free >= FREE_HDR)) begin
                        start_frame = 1'b1;
                        wr_en       = 1'b1;
                        wr_data     = OW'({HDR_TAG, pri_cnt_q, 8'(ch_sel)});
                        state_nxt   = (win_start == 16'd0) ? ST_CAPTURE : ST_DELAY;
                    end else begin
                        skip_frame = 1'b1;
                    end
                end
            end
            ST_DELAY, ST_CAPTURE: begin
                set_flags[FLAG_TRUNC] = pri_edge;
                set_flags[FLAG_LINK]  = ~channel_up;
                if (pri_edge || !channel_up) begin
                    state_nxt = ST_TRAILER;
                end else if (state == ST_DELAY) begin
                    if (in_valid) begin
                        dly_inc = 1'b1;
                        if (dly_cnt + 16'd1 == ws_q) begin
                            state_nxt = ST_CAPTURE;
                        end
                    end
                end else if (cap_cnt == wl_q) begin
                    state_nxt = ST_TRAILER;
                end else if (in_valid) begin
                    // The last free slot belongs to the trailer, so a sample never takes it.
                    if (fifo_free <= FREE_RSV) begin
                        set_flags[FLAG_OVF] = 1'b1;
                    end else begin
                        cap_wr  = 1'b1;
                        wr_en   = 1'b1;
                        wr_data = sample;
                        if (cap_cnt + 16'd1 == wl_q) begin
                            state_nxt = ST_TRAILER;
                        end
                    end
                end
            end
            ST_TRAILER: begin
                wr_en     = 1'b1;
                wr_last   = 1'b1;
                wr_data   = OW'({TRL_TAG, flags, cap_cnt});
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pri_d     <= 1'b0;
            pending   <= 1'b0;
            ch_q      <= '0;
            ws_q      <= '0;
            wl_q      <= '0;
            dly_cnt   <= '0;
            cap_cnt   <= '0;
            flags     <= '0;
            pri_cnt_q <= '0;
        end else begin
            state <= state_nxt;
            pri_d <= PRI;
            // An edge that cuts a frame short is replayed from IDLE after the trailer.
            if (state == ST_IDLE) begin
                pending <= 1'b0;
            end else if (pri_edge) begin
                pending <= 1'b1;
            end
            if (start_frame) begin
                ch_q      <= ch_sel;
                ws_q      <= win_start;
                wl_q      <= win_len;
                dly_cnt   <= '0;
                cap_cnt   <= '0;
                pri_cnt_q <= pri_cnt_q + 16'd1;
            end
            if (dly_inc) begin
                dly_cnt <= dly_cnt + 16'd1;
            end
            if (cap_wr) begin
                cap_cnt <= cap_cnt + 16'd1;
            end
            if (state == ST_TRAILER) begin
                flags <= '0;
            end else begin
                flags <= flags | set_flags;
            end
        end
    end

    always_ff @(posedge clk_100M) begin
        if (!rst_n || err_clr) begin
            hard_cnt  <= '0;
            soft_cnt  <= '0;
            frame_cnt <= '0;
            skip_cnt  <= '0;
        end else begin
            hard_cnt  <= sat_inc(hard_cnt, hard_err);
            soft_cnt  <= sat_inc(soft_cnt, soft_err);
            frame_cnt <= sat_inc(frame_cnt, frame_err);
            skip_cnt  <= sat_inc(skip_cnt, skip_frame);
        end
    end

    pri_iq_fifo #(
        .W  (OW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk      (clk_100M),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_last  (wr_last),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_data  (out_data),
        .rd_last  (out_last),
        .free     (fifo_free)
    );

endmodule
